// File: rtl/atm_controller_mp.sv
// Multi-account ATM session controller: card/language/PIN handshake, per-account
// balances with withdraw/deposit checks, PIN lockout and idle-timeout ejection.
module atm_controller_mp #(
  parameter int         NUM_ACCTS = 4,
  parameter int         BAL_W     = 8,
  parameter int         AMT_W     = 6,
  parameter int         INIT_BAL  = 100,
  parameter logic [3:0] PIN_CODE  = 4'b1111,
  parameter int         MAX_TRIES = 3,
  parameter int         TIMEOUT   = 32,
  localparam int        AW        = $clog2(NUM_ACCTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             insert_card,
  input  logic [AW-1:0]    acct_id,
  input  logic             language_chosen,
  input  logic [3:0]       pin,
  input  logic             pin_valid,
  input  logic [1:0]       operation,
  input  logic             op_valid,
  input  logic [AMT_W-1:0] amount,
  input  logic             home_in,
  input  logic             exit,
  output logic [BAL_W-1:0] check_balance,
  output logic [BAL_W-1:0] final_balance,
  output logic             op_done,
  output logic             err_funds,
  output logic             err_ovf,
  output logic             card_eject,
  output logic             locked
);

  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LANG  = 3'd1,
    S_PIN   = 3'd2,
    S_MENU  = 3'd3,
    S_EJECT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_WITHDRAW = 2'b00,
    OP_DEPOSIT  = 2'b01,
    OP_BALANCE  = 2'b10,
    OP_END      = 2'b11
  } op_t;

  state_t               state, state_d;
  logic [AW-1:0]        acct;
  logic [BAL_W-1:0]     bal   [NUM_ACCTS];
  logic [TW-1:0]        tries [NUM_ACCTS];
  logic [NUM_ACCTS-1:0] lock;
  logic [IW-1:0]        idle_cnt;

  logic                 in_session, activity, timed_out, abort;
  logic [BAL_W-1:0]     cur_bal, amt_ext;
  logic [BAL_W:0]       dep_sum;

  logic                 latch_acct, bal_we, tries_inc, tries_clr, lock_set;
  logic                 op_done_d, err_funds_d, err_ovf_d;
  logic [BAL_W-1:0]     bal_d;

  assign in_session = (state == S_LANG) || (state == S_PIN) || (state == S_MENU);
  assign activity   = pin_valid || op_valid || language_chosen || home_in;
  // The counter reaches TIMEOUT on the same edge that moves the FSM to EJECT.
  assign timed_out  = in_session && !activity && (idle_cnt == IW'(TIMEOUT - 1));
  assign abort      = exit || !insert_card || timed_out;

  assign cur_bal = bal[acct];
  assign amt_ext = BAL_W'(amount);
  assign dep_sum = {1'b0, cur_bal} + (BAL_W + 1)'(amount);

  assign check_balance = (state == S_IDLE) ? '0 : cur_bal;
  assign card_eject    = (state == S_EJECT);
  assign locked        = lock[acct];

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state;
    latch_acct  = 1'b0;
    bal_we      = 1'b0;
    bal_d       = cur_bal;
    tries_inc   = 1'b0;
    tries_clr   = 1'b0;
    lock_set    = 1'b0;
    op_done_d   = 1'b0;
    err_funds_d = 1'b0;
    err_ovf_d   = 1'b0;

    case (state)
      S_IDLE: begin
        if (insert_card) begin
          latch_acct = 1'b1;
          state_d    = lock[acct_id] ? S_EJECT : S_LANG;
        end
      end

      // home_in is ignored before authentication so it cannot bypass the PIN.
      S_LANG: begin
        if (abort)                state_d = S_EJECT;
        else if (language_chosen) state_d = S_PIN;
      end

      S_PIN: begin
        if (abort) begin
          state_d = S_EJECT;
        end else if (pin_valid) begin
          if (pin == PIN_CODE) begin
            tries_clr = 1'b1;
            state_d   = S_MENU;
          end else begin
            tries_inc = 1'b1;
            if (tries[acct] == TW'(MAX_TRIES - 1)) begin
              lock_set = 1'b1;
              state_d  = S_EJECT;
            end
          end
        end
      end

      S_MENU: begin
        if (abort) begin
          state_d = S_EJECT;
        end else if (op_valid && !home_in) begin
          case (op_t'(operation))
            OP_WITHDRAW: begin
              if (amt_ext <= cur_bal) begin
                bal_we    = 1'b1;
                bal_d     = cur_bal - amt_ext;
                op_done_d = 1'b1;
              end else begin
                err_funds_d = 1'b1;
              end
            end
            OP_DEPOSIT: begin
              if (dep_sum[BAL_W]) begin
                err_ovf_d = 1'b1;
              end else begin
                bal_we    = 1'b1;
                bal_d     = dep_sum[BAL_W-1:0];
                op_done_d = 1'b1;
              end
            end
            OP_BALANCE: op_done_d = 1'b1;
            OP_END:     state_d   = S_EJECT;
          endcase
        end
      end

      S_EJECT: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      acct          <= '0;
      // NOTE: the balance and try arrays are reset element by element because a reset restores every account.
      for (int i = 0; i < NUM_ACCTS; i++) begin
        bal[i]   <= BAL_W'(INIT_BAL);
        tries[i] <= '0;
      end
      lock          <= '0;
      idle_cnt      <= '0;
      op_done       <= 1'b0;
      err_funds     <= 1'b0;
      err_ovf       <= 1'b0;
      final_balance <= '0;
    end else begin
      state <= state_d;
      if (latch_acct) acct <= acct_id;
      if (bal_we)     bal[acct] <= bal_d;
      if (tries_clr)      tries[acct] <= '0;
      else if (tries_inc) tries[acct] <= tries[acct] + 1'b1;
      if (lock_set)   lock[acct] <= 1'b1;
      idle_cnt  <= (in_session && !activity) ? idle_cnt + 1'b1 : '0;
      op_done   <= op_done_d;
      err_funds <= err_funds_d;
      err_ovf   <= err_ovf_d;
      if (state == S_EJECT) final_balance <= cur_bal;
    end
  end

endmodule
